// File: rtl/ring_decoder.sv
// One-hot ring-counter decoder: hunts for, acquires and tracks a rotating 4-bit ring sequence.
// Optional revolution counter (rev_count/rev_tick) is built only when RING_DECODER_REV_COUNT_EN is defined.
module ring_decoder #(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       q,
  input  logic             in_valid,
  output logic [1:0]       idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count
`ifdef RING_DECODER_REV_COUNT_EN
  ,
  output logic [7:0]       rev_count,
  output logic             rev_tick
`endif
);

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [1:0] onehot_pos(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             legal, correct;
  logic [3:0]       cnt_inc;
`ifdef RING_DECODER_REV_COUNT_EN
  logic [7:0]       rev_count_q, rev_count_d;
  logic             rev_tick_q, rev_tick_d;
`endif

  always_comb begin
    legal       = $onehot(q);
    correct     = legal && (q == {prev_q[2:0], prev_q[3]});
    cnt_inc     = cnt_q + 4'd1;
    state_d     = state_q;
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    idx_valid_d = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count_q;
`ifdef RING_DECODER_REV_COUNT_EN
    rev_count_d = rev_count_q;
    rev_tick_d  = 1'b0;
`endif
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (legal) begin
            prev_d  = q;
            cnt_d   = 4'd0;
            state_d = ACQ;
          end
        end
        ACQ: begin
          if (!legal) begin
            state_d = HUNT;
          end else if (correct) begin
            prev_d = q;
            cnt_d  = cnt_inc;
            // idx is loaded on the locking sample so it is valid as soon as locked rises
            if (cnt_inc == LOCK_TGT) begin
              state_d = LOCKED;
              idx_d   = onehot_pos(q);
            end
          end else begin
            prev_d = q;
            cnt_d  = 4'd0;
          end
        end
        LOCKED: begin
          if (correct) begin
            prev_d      = q;
            idx_d       = onehot_pos(q);
            idx_valid_d = 1'b1;
`ifdef RING_DECODER_REV_COUNT_EN
            if (q == 4'b0001) begin
              rev_count_d = rev_count_q + 8'd1;
              rev_tick_d  = 1'b1;
            end
`endif
          end else begin
            err_d       = 1'b1;
            err_count_d = sat_inc(err_count_q);
            cnt_d       = 4'd0;
            state_d     = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      prev_q      <= 4'd0;
      cnt_q       <= 4'd0;
      idx_q       <= 2'd0;
      idx_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
`ifdef RING_DECODER_REV_COUNT_EN
      rev_count_q <= 8'd0;
      rev_tick_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
`ifdef RING_DECODER_REV_COUNT_EN
      rev_count_q <= rev_count_d;
      rev_tick_q  <= rev_tick_d;
`endif
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;
`ifdef RING_DECODER_REV_COUNT_EN
  assign rev_count = rev_count_q;
  assign rev_tick  = rev_tick_q;
`endif

endmodule

// File: doc/ring_decoder.md
RING_DECODER -- requirements
Module: ring_decoder

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 3: consecutive correct ring transitions needed to enter LOCKED (legal range 1..15).
REQ-002 SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port q, input, 4: sampled ring-counter value (expected sequence 0001->0010->0100->1000->0001).
REQ-006 SHALL have port in_valid, input, 1: q is meaningful this cycle; when low, the sample is ignored.
REQ-007 SHALL have port idx, output, 2: binary position of the set bit in the last accepted one-hot sample.
REQ-008 SHALL have port idx_valid, output, 1: one-cycle pulse; idx was updated from a legal sample while LOCKED.
REQ-009 SHALL have port locked, output, 1: high in state LOCKED.
REQ-010 SHALL have port err, output, 1: one-cycle pulse on any sequence or encoding violation detected while LOCKED.
REQ-011 SHALL have port err_count, output, ERR_W: saturating count of err pulses.

Function
REQ-012 SHALL implement FSM states HUNT, ACQ, LOCKED.
REQ-013 SHALL classify an accepted sample as legal one-hot only when exactly one bit of q is set; 0000 and multi-hot values are illegal.
REQ-014 SHALL treat a transition as correct when the current legal sample equals the previous accepted sample rotated left by one ({prev[2:0],prev[3]}).
REQ-015 HUNT: a legal sample SHALL be stored as prev and move to ACQ with the match counter cleared; an illegal sample SHALL keep the FSM in HUNT.
REQ-016 ACQ: a correct transition SHALL increment the match counter; on reaching LOCK_CNT the FSM SHALL move to LOCKED in the same cycle.
REQ-017 ACQ: a legal but out-of-sequence sample SHALL restart acquisition (prev updated, counter cleared, stay ACQ); an illegal sample SHALL return to HUNT.
REQ-018 LOCKED: a correct transition SHALL update prev and idx and pulse idx_valid; any other sample SHALL pulse err, increment err_count, and move to HUNT.
REQ-019 Samples with in_valid low SHALL NOT change state, prev, counters, or idx; idx_valid and err SHALL be low that cycle.
REQ-020 A repeated identical sample (no rotation) SHALL count as an out-of-sequence sample.
REQ-021 idx, idx_valid, err, and locked SHALL be registered, with one-cycle latency from the sampling edge to the outputs.
REQ-022 err_count SHALL saturate at all-ones and never wrap.
REQ-023 idx SHALL hold its last value while not LOCKED.

Reset
REQ-024 When rst is high at a clock edge, the block SHALL set the FSM to HUNT and clear prev, the match counter, idx, idx_valid, locked, err, and err_count.
REQ-025 Reset SHALL override in_valid and any in-progress acquisition or lock in the same edge.
REQ-026 The first edge after rst deasserts SHALL process q normally from HUNT.

Configuration
REQ-027 With macro RING_DECODER_REV_COUNT_EN defined, the block SHALL add output rev_count[7:0] and output rev_tick.
REQ-028 Under that macro, rev_count SHALL increment (wrapping 255->0) and rev_tick SHALL pulse for one cycle on each LOCKED correct transition into 0001.
REQ-029 Under that macro, rev_count SHALL be cleared by reset.
REQ-030 Without the macro, those ports and that logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL apply rst for 1 cycle and then drive 0001, 0010, 0100, 1000 with in_valid=1, and SHALL check that locked rises after the 4th sample edge (LOCK_CNT=3) and that idx=3.
REQ-032 While locked, the bench SHALL drive 0001 then 0100, and SHALL check that err pulses once, err_count=1, locked drops, and the FSM is in HUNT.
REQ-033 The bench SHALL drive 0000 and then 0011 from HUNT, and SHALL check that the FSM stays in HUNT with err=0 and locked=0.
REQ-034 While locked, the bench SHALL hold in_valid=0 for 5 cycles with garbage q, and SHALL check that there is no err pulse, no idx_valid pulse, locked stays 1, and the next correct sample is accepted.
REQ-035 While locked, the bench SHALL assert rst, and SHALL check that on the next edge locked=0, err_count=0, idx=0, and reacquisition requires LOCK_CNT fresh transitions.
REQ-036 The bench SHALL force 300 lock/error cycles with ERR_W=8, and SHALL check that err_count saturates at 255; with RING_DECODER_REV_COUNT_EN defined, it SHALL check that rev_count increments once per 0001 while locked.
